ifetch_thread_sched: RTL and testbench



---
 rtl/ifetch_thread_sched.sv | 115 +++++++++++
 tb/tb_ifetch_thread_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_thread_sched.sv
// Instruction-fetch thread scheduler: round-robin thread pick, per-thread PC file, miss parking.
// Optional priority scheduling over thread_high_pri is enabled by defining IFETCH_PRIORITY_EN.
module ifetch_thread_sched #(
    parameter int                  NUM_THREADS = 4,
    parameter int                  PC_WIDTH    = 32,
    parameter int                  FETCH_BYTES = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_THREADS-1:0]         ts_fetch_en,
    input  logic                           fetch_block,
    input  logic                           ifd_cache_miss,
    input  logic                           ifd_near_miss,
    input  logic [$clog2(NUM_THREADS)-1:0] ifd_miss_thread_idx,
    input  logic [NUM_THREADS-1:0]         l2i_icache_wake_bitmap,
    input  logic                           wb_rollback_en,
    input  logic [$clog2(NUM_THREADS)-1:0] wb_rollback_thread_idx,
    input  logic [PC_WIDTH-1:0]            wb_rollback_pc,
`ifdef IFETCH_PRIORITY_EN
    input  logic [NUM_THREADS-1:0]         thread_high_pri,
`endif
    output logic                           fetch_valid,
    output logic [PC_WIDTH-1:0]            fetch_pc,
    output logic [$clog2(NUM_THREADS)-1:0] fetch_thread_idx,
    output logic [NUM_THREADS-1:0]         icache_wait_bitmap
);

    localparam int                  IDX_W      = $clog2(NUM_THREADS);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(FETCH_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(FETCH_BYTES - 1);

    logic [PC_WIDTH-1:0]    pc      [NUM_THREADS];
    logic [PC_WIDTH-1:0]    last_pc [NUM_THREADS];
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant;
    logic                   found;
    logic                   select_en;
    logic                   suppress;
    logic [NUM_THREADS-1:0] ready;
    logic [NUM_THREADS-1:0] cand;
    logic [NUM_THREADS-1:0] rb_hit;
    logic [NUM_THREADS-1:0] rewind_hit;
    logic [NUM_THREADS-1:0] miss_set;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ready = ts_fetch_en & ~icache_wait_bitmap;
        cand  = ready;
`ifdef IFETCH_PRIORITY_EN
        if (|(ready & thread_high_pri)) begin
            cand = ready & thread_high_pri;
        end
`endif
        select_en = (|ready) && !fetch_block;

        grant = rr_ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_THREADS;
            if (!found && cand[IDX_W'(idx)]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end

        for (int t = 0; t < NUM_THREADS; t++) begin
            rb_hit[t]     = wb_rollback_en && (wb_rollback_thread_idx == IDX_W'(t));
            rewind_hit[t] = (ifd_cache_miss || ifd_near_miss) && (ifd_miss_thread_idx == IDX_W'(t));
            miss_set[t]   = ifd_cache_miss && (ifd_miss_thread_idx == IDX_W'(t));
        end

        suppress = rb_hit[grant] || rewind_hit[grant];
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the PC file is reset on purpose; each thread must restart at RESET_PC.
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc[t]      <= RESET_PC;
                last_pc[t] <= RESET_PC;
            end
            rr_ptr             <= IDX_W'(NUM_THREADS - 1);
            fetch_valid        <= 1'b0;
            fetch_pc           <= '0;
            fetch_thread_idx   <= '0;
            icache_wait_bitmap <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (rb_hit[t]) begin
                    pc[t] <= wb_rollback_pc & ALIGN_MASK;
                end else if (rewind_hit[t]) begin
                    pc[t] <= last_pc[t];
                end else if (select_en && (grant == IDX_W'(t))) begin
                    pc[t] <= pc[t] + STEP;
                end
                if (select_en && (grant == IDX_W'(t))) begin
                    last_pc[t] <= pc[t];
                end
            end

            // Pointer advances even when the issued fetch is suppressed.
            if (select_en) begin
                rr_ptr           <= grant;
                fetch_pc         <= pc[grant];
                fetch_thread_idx <= grant;
            end
            fetch_valid        <= select_en && !suppress;
            icache_wait_bitmap <= (icache_wait_bitmap | miss_set) & ~l2i_icache_wake_bitmap;
        end
    end

endmodule

// File: tb/tb_ifetch_thread_sched.sv
// Self-checking bench for ifetch_thread_sched: directed scenarios plus random traffic
// against a behavioural model of the thread scheduler and PC file.
module tb_ifetch_thread_sched;

    localparam int N   = 4;
    localparam int PCW = 32;
    localparam int FB  = 16;
    localparam logic [PCW-1:0] RPC = '0;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   ts_fetch_en;
    logic           fetch_block;
    logic           ifd_cache_miss;
    logic           ifd_near_miss;
    logic [1:0]     ifd_miss_thread_idx;
    logic [N-1:0]   l2i_icache_wake_bitmap;
    logic           wb_rollback_en;
    logic [1:0]     wb_rollback_thread_idx;
    logic [PCW-1:0] wb_rollback_pc;
    logic [N-1:0]   thread_high_pri;
    logic           fetch_valid;
    logic [PCW-1:0] fetch_pc;
    logic [1:0]     fetch_thread_idx;
    logic [N-1:0]   icache_wait_bitmap;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [PCW-1:0] m_pc   [N];
    logic [PCW-1:0] m_last [N];
    int             m_ptr;
    logic [N-1:0]   m_wait;
    logic           m_valid;
    logic [PCW-1:0] m_fpc;
    int             m_fidx;

    always #5 clk = ~clk;

    ifetch_thread_sched #(
        .NUM_THREADS(N), .PC_WIDTH(PCW), .FETCH_BYTES(FB), .RESET_PC(RPC)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ts_fetch_en            (ts_fetch_en),
        .fetch_block            (fetch_block),
        .ifd_cache_miss         (ifd_cache_miss),
        .ifd_near_miss          (ifd_near_miss),
        .ifd_miss_thread_idx    (ifd_miss_thread_idx),
        .l2i_icache_wake_bitmap (l2i_icache_wake_bitmap),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .wb_rollback_pc         (wb_rollback_pc),
`ifdef IFETCH_PRIORITY_EN
        .thread_high_pri        (thread_high_pri),
`endif
        .fetch_valid            (fetch_valid),
        .fetch_pc               (fetch_pc),
        .fetch_thread_idx       (fetch_thread_idx),
        .icache_wait_bitmap     (icache_wait_bitmap)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from current inputs, then compare after the edge.
    task automatic cycle();
        logic [PCW-1:0] n_pc [N];
        logic [PCW-1:0] n_last [N];
        logic [N-1:0]   rdy, cand, n_wait;
        bit             sel, fnd, n_valid;
        int             g, n_ptr, n_fidx;
        logic [PCW-1:0] n_fpc;

        if (reset) begin
            for (int t = 0; t < N; t++) begin
                n_pc[t] = RPC; n_last[t] = RPC;
            end
            n_ptr = N - 1; n_wait = '0; n_valid = 0; n_fpc = '0; n_fidx = 0;
        end else begin
            rdy  = ts_fetch_en & ~m_wait;
            cand = rdy;
`ifdef IFETCH_PRIORITY_EN
            if ((rdy & thread_high_pri) != 0) cand = rdy & thread_high_pri;
`endif
            sel = (rdy != 0) && !fetch_block;
            g = m_ptr; fnd = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!fnd && ((cand >> c) & 1) != 0) begin g = c; fnd = 1; end
            end
            for (int t = 0; t < N; t++) begin
                n_last[t] = (sel && g == t) ? m_pc[t] : m_last[t];
                if (wb_rollback_en && wb_rollback_thread_idx == t)
                    n_pc[t] = wb_rollback_pc - (wb_rollback_pc % FB);
                else if ((ifd_cache_miss || ifd_near_miss) && ifd_miss_thread_idx == t)
                    n_pc[t] = m_last[t];
                else if (sel && g == t)
                    n_pc[t] = m_pc[t] + FB;
                else
                    n_pc[t] = m_pc[t];
            end
            n_valid = sel
                && !(wb_rollback_en && wb_rollback_thread_idx == g)
                && !((ifd_cache_miss || ifd_near_miss) && ifd_miss_thread_idx == g);
            n_ptr  = sel ? g : m_ptr;
            n_fpc  = sel ? m_pc[g] : m_fpc;
            n_fidx = sel ? g : m_fidx;
            n_wait = m_wait;
            if (ifd_cache_miss) n_wait = n_wait | (N'(1) << ifd_miss_thread_idx);
            n_wait = n_wait & ~l2i_icache_wake_bitmap;
        end

        @(posedge clk);
        #1;
        m_pc = n_pc; m_last = n_last; m_ptr = n_ptr; m_wait = n_wait;
        m_valid = n_valid; m_fpc = n_fpc; m_fidx = n_fidx;

        check("fetch_valid", fetch_valid, m_valid);
        check("wait_bitmap", icache_wait_bitmap, m_wait);
        if (m_valid || reset) begin
            check("fetch_pc", fetch_pc, m_fpc);
            check("fetch_thread_idx", fetch_thread_idx, m_fidx);
        end
    endtask

    task automatic wait_fetch(input int t, input int budget, output logic [PCW-1:0] p);
        bit got = 0;
        p = '0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (fetch_valid && fetch_thread_idx == 2'(t)) begin
                got = 1; p = fetch_pc;
            end
        end
        check("fetch_seen_within_budget", 64'(got), 64'd1);
    endtask

    logic [PCW-1:0] p;
    logic [PCW-1:0] exp_pc;

    initial begin
        reset = 1; ts_fetch_en = '0; fetch_block = 0;
        ifd_cache_miss = 0; ifd_near_miss = 0; ifd_miss_thread_idx = '0;
        l2i_icache_wake_bitmap = '0; wb_rollback_en = 0;
        wb_rollback_thread_idx = '0; wb_rollback_pc = '0; thread_high_pri = '0;
        repeat (2) cycle();
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_fetch_pc", fetch_pc, 0);
        check("rst_fetch_idx", fetch_thread_idx, 0);
        check("rst_wait", icache_wait_bitmap, 0);

        // Plain round-robin over all four threads
        reset = 0; ts_fetch_en = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_valid", fetch_valid, 1);
            check("rr_idx", fetch_thread_idx, 64'(i % 4));
            check("rr_pc", fetch_pc, 64'((i / 4) * FB));
        end

        // Rollback on the thread granted this cycle (thread 1), unaligned target
        wb_rollback_en = 1; wb_rollback_thread_idx = 2'd1; wb_rollback_pc = 32'h1234;
        cycle();
        wb_rollback_en = 0;
        check("rb_granted_suppressed", fetch_valid, 0);
        wait_fetch(1, 8, p);
        check("rb_first_pc", p, 32'h1230);
        wait_fetch(1, 8, p);
        check("rb_second_pc", p, 32'h1240);

        // Park thread 2 after it fetched 0x40, then wake it
        wb_rollback_en = 1; wb_rollback_thread_idx = 2'd2; wb_rollback_pc = 32'h40;
        cycle();
        wb_rollback_en = 0;
        wait_fetch(2, 8, p);
        check("t2_pc_before_miss", p, 32'h40);
        ifd_cache_miss = 1; ifd_miss_thread_idx = 2'd2;
        cycle();
        ifd_cache_miss = 0;
        check("t2_parked_bitmap", icache_wait_bitmap, 4'b0100);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t2_not_issued", 64'(fetch_valid && fetch_thread_idx == 2'd2), 0);
        end
        l2i_icache_wake_bitmap = 4'b0100;
        cycle();
        l2i_icache_wake_bitmap = '0;
        check("t2_woken_bitmap", icache_wait_bitmap, 0);
        wait_fetch(2, 8, p);
        check("t2_refetch_pc", p, 32'h40);

        // Miss and wake on thread 3 together: stays awake, rewinds
        exp_pc = m_last[3];
        ifd_cache_miss = 1; ifd_miss_thread_idx = 2'd3; l2i_icache_wake_bitmap = 4'b1000;
        cycle();
        ifd_cache_miss = 0; l2i_icache_wake_bitmap = '0;
        check("t3_miss_wake_bitmap", icache_wait_bitmap, 0);
        wait_fetch(3, 8, p);
        check("t3_rewound_pc", p, exp_pc);

`ifdef IFETCH_PRIORITY_EN
        thread_high_pri = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("pri_only_t2", fetch_thread_idx, 2);
            check("pri_valid", fetch_valid, 1);
        end
        thread_high_pri = '0;
        cycle();
        check("pri_resume_t3", fetch_thread_idx, 3);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ts_fetch_en            = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            fetch_block            = ($urandom_range(0, 9) == 0);
            ifd_cache_miss         = ($urandom_range(0, 9) == 0);
            ifd_near_miss          = ($urandom_range(0, 9) == 0);
            ifd_miss_thread_idx    = 2'($urandom);
            l2i_icache_wake_bitmap = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            wb_rollback_en         = ($urandom_range(0, 7) == 0);
            wb_rollback_thread_idx = 2'($urandom);
            wb_rollback_pc         = $urandom;
            thread_high_pri        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            cycle();
        end

        // Reset in the middle of traffic discards everything
        reset = 1;
        cycle();
        check("midrst_wait", icache_wait_bitmap, 0);
        check("midrst_valid", fetch_valid, 0);
        reset = 0; ts_fetch_en = 4'b1111; fetch_block = 0; ifd_cache_miss = 0;
        ifd_near_miss = 0; l2i_icache_wake_bitmap = '0; wb_rollback_en = 0; thread_high_pri = '0;
        cycle();
        check("post_rst_idx", fetch_thread_idx, 0);
        check("post_rst_pc", fetch_pc, 64'(RPC));
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
